// File: rtl/crp16_pkg.sv
// crp16_pkg: shared widths, register-zero constant and forwarding helper for the crp16 pipeline
package crp16_pkg;
    localparam int REG_W = 16;
    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS = 16;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 4'd0;
    localparam int OP_W_DEFAULT = 5;

    // a writeback to x is visible to a same-cycle reader of x; register 0 never forwards
    function automatic logic fwd_hit(
        input logic                 wb_write,
        input logic [REG_IDX_W-1:0] wb_select,
        input logic [REG_IDX_W-1:0] x
    );
        return wb_write && wb_select == x && x != REG_ZERO;
    endfunction
endpackage

// File: rtl/crp16_operand_fetch_if.sv
// crp16_operand_fetch_if: decode, register-file, writeback and execute signals of the operand fetch stage
interface crp16_operand_fetch_if
    import crp16_pkg::*;
#(
    parameter int OP_W = OP_W_DEFAULT
);
    logic                 dec_valid;
    logic                 dec_ready;
    logic [REG_IDX_W-1:0] dec_rs_a;
    logic [REG_IDX_W-1:0] dec_rs_b;
    logic [REG_IDX_W-1:0] dec_rd;
    logic                 dec_wen;
    logic [OP_W-1:0]      dec_op;
    logic [REG_W-1:0]     dec_imm;
    logic [REG_IDX_W-1:0] rf_a_select;
    logic [REG_IDX_W-1:0] rf_b_select;
    logic [REG_W-1:0]     rf_a_val;
    logic [REG_W-1:0]     rf_b_val;
    logic                 wb_write;
    logic [REG_IDX_W-1:0] wb_select;
    logic [REG_W-1:0]     wb_val;
    logic                 ex_valid;
    logic                 ex_ready;
    logic [REG_W-1:0]     ex_a;
    logic [REG_W-1:0]     ex_b;
    logic [REG_W-1:0]     ex_imm;
    logic [OP_W-1:0]      ex_op;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_wen;

    modport master (
        output dec_valid, dec_rs_a, dec_rs_b, dec_rd, dec_wen, dec_op, dec_imm,
        output rf_a_val, rf_b_val, wb_write, wb_select, wb_val, ex_ready,
        input  dec_ready, rf_a_select, rf_b_select,
        input  ex_valid, ex_a, ex_b, ex_imm, ex_op, ex_rd, ex_wen
    );

    modport slave (
        input  dec_valid, dec_rs_a, dec_rs_b, dec_rd, dec_wen, dec_op, dec_imm,
        input  rf_a_val, rf_b_val, wb_write, wb_select, wb_val, ex_ready,
        output dec_ready, rf_a_select, rf_b_select,
        output ex_valid, ex_a, ex_b, ex_imm, ex_op, ex_rd, ex_wen
    );
endinterface

// File: rtl/crp16_scoreboard.sv
// crp16_scoreboard: one pending-write bit per writable register, a new writer outranks a retiring one
module crp16_scoreboard
    import crp16_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]  busy
);
    logic [NUM_REGS-1:0] busy_nxt;

    // retire first, then mark the newly issued writer so it wins on a shared index
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    // reset drops every pending write
    always_ff @(posedge clock) begin
        busy <= resetn ? busy_nxt : '0;
    end
endmodule

// File: rtl/crp16_operand_fetch.sv
// crp16_operand_fetch: reads operands with writeback forwarding, stalls on pending writers, registers them for execute
module crp16_operand_fetch
    import crp16_pkg::*;
#(
    parameter int OP_W = OP_W_DEFAULT
) (
    input logic                  clock,
    input logic                  resetn,
    crp16_operand_fetch_if.slave bus
);
    logic [NUM_REGS-1:0]  busy;
    logic                 fwd_a, fwd_b, fwd_d;
    logic                 space, hazard, issue, set_en;
    logic [REG_W-1:0]     opnd_a, opnd_b;
    logic                 valid_q, wen_q;
    logic [REG_W-1:0]     a_q, b_q, imm_q;
    logic [OP_W-1:0]      op_q;
    logic [REG_IDX_W-1:0] rd_q;

    assign bus.rf_a_select = bus.dec_rs_a;
    assign bus.rf_b_select = bus.dec_rs_b;

    // the register file updates on the capture edge, so a same-cycle writeback must bypass it
    assign fwd_a  = fwd_hit(bus.wb_write, bus.wb_select, bus.dec_rs_a);
    assign fwd_b  = fwd_hit(bus.wb_write, bus.wb_select, bus.dec_rs_b);
    assign fwd_d  = fwd_hit(bus.wb_write, bus.wb_select, bus.dec_rd);
    assign opnd_a = bus.dec_rs_a == REG_ZERO ? '0 : fwd_a ? bus.wb_val : bus.rf_a_val;
    assign opnd_b = bus.dec_rs_b == REG_ZERO ? '0 : fwd_b ? bus.wb_val : bus.rf_b_val;

    // busy[0] is held low, so register 0 sources never raise a hazard
    assign hazard = (busy[bus.dec_rs_a] && !fwd_a) ||
                    (busy[bus.dec_rs_b] && !fwd_b) ||
                    (bus.dec_wen && bus.dec_rd != REG_ZERO && busy[bus.dec_rd] && !fwd_d);
    assign space         = !valid_q || bus.ex_ready;
    assign bus.dec_ready = space && !hazard;
    assign issue         = bus.dec_valid && bus.dec_ready;
    assign set_en        = issue && bus.dec_wen && bus.dec_rd != REG_ZERO;

    crp16_scoreboard u_sb (
        .clock   (clock),
        .resetn  (resetn),
        .set_en  (set_en),
        .set_idx (bus.dec_rd),
        .clr_en  (bus.wb_write),
        .clr_idx (bus.wb_select),
        .busy    (busy)
    );

    // output pipeline register: load on issue, drain on consume, otherwise hold
    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
        end else if (issue) begin
            valid_q <= 1'b1;
            a_q     <= opnd_a;
            b_q     <= opnd_b;
            imm_q   <= bus.dec_imm;
            op_q    <= bus.dec_op;
            rd_q    <= bus.dec_rd;
            wen_q   <= bus.dec_wen && bus.dec_rd != REG_ZERO;
        end else if (bus.ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid = valid_q;
    assign bus.ex_a     = a_q;
    assign bus.ex_b     = b_q;
    assign bus.ex_imm   = imm_q;
    assign bus.ex_op    = op_q;
    assign bus.ex_rd    = rd_q;
    assign bus.ex_wen   = wen_q;
endmodule

// File: tb/tb_crp16_operand_fetch.sv
// tb_crp16_operand_fetch: directed test plan plus randomized traffic against a behavioural model
module tb_crp16_operand_fetch;
    import crp16_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    crp16_operand_fetch_if #(.OP_W(5)) bus ();

    crp16_operand_fetch #(.OP_W(5)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    logic [15:0] m_busy = '0;
    logic        m_v = 1'b0;
    logic        m_wen = 1'b0;
    logic [15:0] m_a = '0, m_b = '0, m_imm = '0;
    logic [4:0]  m_op = '0;
    logic [3:0]  m_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit wb_to(input logic [3:0] x);
        return bus.wb_write && bus.wb_select == x && x != 4'd0;
    endfunction

    function automatic bit m_blocked(input logic [3:0] x);
        return x != 4'd0 && m_busy[x] && !wb_to(x);
    endfunction

    function automatic bit m_ready();
        return (!m_v || bus.ex_ready) && !m_blocked(bus.dec_rs_a) && !m_blocked(bus.dec_rs_b) &&
               !(bus.dec_wen && m_blocked(bus.dec_rd));
    endfunction

    function automatic logic [15:0] m_src(input logic [3:0] x, input logic [15:0] rf);
        return x == 4'd0 ? 16'h0000 : wb_to(x) ? bus.wb_val : rf;
    endfunction

    // advance one clock, updating the model from the inputs present before the edge
    task automatic cyc();
        bit          iss;
        logic [15:0] nb;
        logic        nv, nwen;
        logic [15:0] na, nbv, nimm;
        logic [4:0]  nop;
        logic [3:0]  nrd;
        iss = bus.dec_valid && m_ready();
        nb = m_busy;
        nv = m_v; na = m_a; nbv = m_b; nimm = m_imm; nop = m_op; nrd = m_rd; nwen = m_wen;
        if (bus.wb_write && bus.wb_select != 4'd0) nb[bus.wb_select] = 1'b0;
        if (iss && bus.dec_wen && bus.dec_rd != 4'd0) nb[bus.dec_rd] = 1'b1;
        if (iss) begin
            nv = 1'b1;
            na = m_src(bus.dec_rs_a, bus.rf_a_val);
            nbv = m_src(bus.dec_rs_b, bus.rf_b_val);
            nimm = bus.dec_imm;
            nop = bus.dec_op;
            nrd = bus.dec_rd;
            nwen = bus.dec_wen && bus.dec_rd != 4'd0;
        end else if (bus.ex_ready) begin
            nv = 1'b0;
        end
        if (!resetn) begin
            nb = '0; nv = 1'b0; na = '0; nbv = '0; nimm = '0; nop = '0; nrd = '0; nwen = 1'b0;
        end
        @(posedge clock);
        #1;
        m_busy = nb; m_v = nv; m_a = na; m_b = nbv; m_imm = nimm; m_op = nop; m_rd = nrd; m_wen = nwen;
    endtask

    task automatic dec(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rd, input logic wen, input logic [15:0] imm);
        bus.dec_valid = v;
        bus.dec_rs_a = ra;
        bus.dec_rs_b = rb;
        bus.dec_rd = rd;
        bus.dec_wen = wen;
        bus.dec_imm = imm;
        bus.dec_op = imm[4:0];
    endtask

    task automatic rf(input logic [15:0] a, input logic [15:0] b);
        bus.rf_a_val = a;
        bus.rf_b_val = b;
    endtask

    task automatic wb(input logic w, input logic [3:0] s, input logic [15:0] v);
        bus.wb_write = w;
        bus.wb_select = s;
        bus.wb_val = v;
    endtask

    // every-cycle comparison of the DUT against the model, away from the active edge
    always @(negedge clock) begin
        if (run) begin
            chk("dec_ready", bus.dec_ready, m_ready());
            chk("rf_a_select", bus.rf_a_select, bus.dec_rs_a);
            chk("rf_b_select", bus.rf_b_select, bus.dec_rs_b);
            chk("ex_valid", bus.ex_valid, m_v);
            chk("busy", dut.busy, m_busy);
            if (m_v) begin
                chk("ex_a", bus.ex_a, m_a);
                chk("ex_b", bus.ex_b, m_b);
                chk("ex_imm", bus.ex_imm, m_imm);
                chk("ex_op", bus.ex_op, m_op);
                chk("ex_rd", bus.ex_rd, m_rd);
                chk("ex_wen", bus.ex_wen, m_wen);
            end
        end
    end

    initial begin
        dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
        rf(16'h0, 16'h0);
        wb(1'b0, 4'd0, 16'h0);
        bus.ex_ready = 1'b1;
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        run = 1'b1;

        // 1: plain issue captures register-file values and marks rd pending
        dec(1'b1, 4'd3, 4'd4, 4'd5, 1'b1, 16'h00AA);
        rf(16'h1111, 16'h2222);
        #1 chk("t1_ready", bus.dec_ready, 1'b1);
        cyc();
        chk("t1_valid", bus.ex_valid, 1'b1);
        chk("t1_a", bus.ex_a, 16'h1111);
        chk("t1_b", bus.ex_b, 16'h2222);
        chk("t1_wen", bus.ex_wen, 1'b1);
        chk("t1_busy5", dut.busy[5], 1'b1);

        // 2: RAW stall, then same-cycle writeback forwards into the retry
        dec(1'b1, 4'd5, 4'd0, 4'd6, 1'b0, 16'h0022);
        rf(16'h5555, 16'h6666);
        #1 chk("t2_stall", bus.dec_ready, 1'b0);
        cyc();
        wb(1'b1, 4'd5, 16'hBEEF);
        #1 chk("t2_ready", bus.dec_ready, 1'b1);
        cyc();
        chk("t2_fwd_a", bus.ex_a, 16'hBEEF);
        chk("t2_busy5", dut.busy[5], 1'b0);

        // 3: register 0 reads as zero and ignores writeback
        dec(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 16'h3333);
        rf(16'hFFFF, 16'hFFFF);
        wb(1'b1, 4'd0, 16'h1234);
        #1 chk("t3_ready", bus.dec_ready, 1'b1);
        cyc();
        chk("t3_a", bus.ex_a, 16'h0);
        chk("t3_b", bus.ex_b, 16'h0);
        chk("t3_wen", bus.ex_wen, 1'b0);
        chk("t3_busy", dut.busy, 16'h0);

        // 4: backpressure freezes outputs, then back-to-back issue
        wb(1'b0, 4'd0, 16'h0);
        bus.ex_ready = 1'b0;
        dec(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 16'h4444);
        rf(16'h0101, 16'h0202);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_stall", bus.dec_ready, 1'b0);
            cyc();
            chk("t4_hold_imm", bus.ex_imm, 16'h3333);
            chk("t4_hold_valid", bus.ex_valid, 1'b1);
        end
        bus.ex_ready = 1'b1;
        #1 chk("t4_ready", bus.dec_ready, 1'b1);
        cyc();
        chk("t4_imm1", bus.ex_imm, 16'h4444);
        dec(1'b1, 4'd1, 4'd2, 4'd4, 1'b1, 16'h5555);
        #1 chk("t4_ready2", bus.dec_ready, 1'b1);
        cyc();
        chk("t4_imm2", bus.ex_imm, 16'h5555);
        chk("t4_valid2", bus.ex_valid, 1'b1);

        // 5: WAW stall, retire and re-set of the same register in one cycle
        dec(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 16'h7000);
        cyc();
        dec(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 16'h7001);
        #1 chk("t5_stall", bus.dec_ready, 1'b0);
        cyc();
        wb(1'b1, 4'd7, 16'h0);
        #1 chk("t5_ready", bus.dec_ready, 1'b1);
        cyc();
        chk("t5_busy7", dut.busy[7], 1'b1);
        chk("t5_imm", bus.ex_imm, 16'h7001);

        // 6: reset mid-operation discards held instruction and pending writes
        wb(1'b0, 4'd0, 16'h0);
        rf(16'hAAAA, 16'hBBBB);
        dec(1'b1, 4'd1, 4'd1, 4'd2, 1'b1, 16'h0002);
        cyc();
        dec(1'b1, 4'd1, 4'd1, 4'd9, 1'b1, 16'h0009);
        cyc();
        bus.ex_ready = 1'b0;
        chk("t6_busy2", dut.busy[2], 1'b1);
        chk("t6_busy9", dut.busy[9], 1'b1);
        chk("t6_valid", bus.ex_valid, 1'b1);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        chk("t6_rst_valid", bus.ex_valid, 1'b0);
        chk("t6_rst_a", bus.ex_a, 16'h0);
        chk("t6_rst_b", bus.ex_b, 16'h0);
        chk("t6_rst_imm", bus.ex_imm, 16'h0);
        chk("t6_rst_op", bus.ex_op, 5'h0);
        chk("t6_rst_rd", bus.ex_rd, 4'h0);
        chk("t6_rst_wen", bus.ex_wen, 1'b0);
        chk("t6_rst_busy", dut.busy, 16'h0);
        bus.ex_ready = 1'b1;
        dec(1'b1, 4'd2, 4'd9, 4'd9, 1'b1, 16'h0010);
        #1 chk("t6_ready", bus.dec_ready, 1'b1);
        cyc();

        // randomized traffic, every cycle checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            resetn = $urandom_range(0, 199) != 0;
            dec($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 16'($urandom));
            rf(16'($urandom), 16'($urandom));
            wb($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 16'($urandom));
            bus.ex_ready = $urandom_range(0, 3) != 0;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
